// File: rtl/result_disp_pkg.sv
// Shared types and constants for the result display sequencer.
// Display codes above 9 decode to an all-off (active-low) segment pattern.
package result_disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_e;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/result_display_ctrl_if.sv
// Result handshake bundle: res_valid/res_ready transfer res_digit and res_count.
// Handshake: a transfer happens on a rising edge where res_valid && res_ready; the
// source holds res_valid and its data stable until then, and ready never waits on valid.
interface result_display_ctrl_if #(
  parameter int COUNT_W = 16
);
  logic               res_valid;
  logic               res_ready;
  logic [3:0]         res_digit;
  logic [COUNT_W-1:0] res_count;

  modport master (output res_valid, output res_digit, output res_count, input res_ready);
  modport slave  (input res_valid, input res_digit, input res_count, output res_ready);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle.
// done is high in the cycle whose closing edge performs the final shift.
module bin_to_bcd_seq #(
  parameter int COUNT_W    = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [COUNT_W-1:0]      bin_i,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);
  localparam int CNT_W = $clog2(COUNT_W + 1);

  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
  logic [COUNT_W-1:0]      shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d   = bcd_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      bcd_d   = '0;
      shift_d = bin_i;
      cnt_d   = CNT_W'(COUNT_W);
    end else if (cnt_q != '0) begin
      {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
      cnt_d            = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      bcd_q   <= bcd_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done  = (cnt_q == CNT_W'(1)) && !abort;
  assign bcd_o = bcd_q;
endmodule

// File: rtl/segment7.sv
// Active-low seven-segment decoder, bit order {g,f,e,d,c,b,a}; codes 10-15 are blank.
module segment7
  import result_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);
  always_comb begin
    case (code)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/result_display_ctrl.sv
// Display sequencer: accepts a classification result, converts the count to BCD,
// blanks leading zeros and holds the six seven-segment outputs in registers.
module result_display_ctrl
  import result_disp_pkg::*;
#(
  parameter int COUNT_W       = 16,
  parameter int NUM_DIGITS    = 5,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  result_display_ctrl_if.slave        res,
  input  logic                        clear,
  output logic                        busy,
  output logic                        update_done,
  output logic [6:0]                  hex_digit,
  output logic [NUM_DIGITS-1:0][6:0]  hex_count,
  output state_e                      state_dbg
);
  if (pow10(NUM_DIGITS) <= ((64'd1 << COUNT_W) - 64'd1)) begin : g_bad_digits
    $error("NUM_DIGITS too small to show every COUNT_W-bit count");
  end

  state_e                      state_q, state_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [3:0]                  digit_cap_q, digit_cap_d;
  logic [3:0]                  digit_code_q, digit_code_d;
  logic [NUM_DIGITS-1:0][3:0]  count_code_q, count_code_d, blanked;
  logic [4*NUM_DIGITS-1:0]     bcd;
  logic                        bcd_done, accept, lead_seen;

  assign res.res_ready = (state_q == IDLE) && !clear;
  assign accept        = res.res_valid && res.res_ready;

  bin_to_bcd_seq #(.COUNT_W(COUNT_W), .NUM_DIGITS(NUM_DIGITS)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .abort (clear),
    .bin_i (res.res_count),
    .done  (bcd_done),
    .bcd_o (bcd)
  );

  // Scan from the top nibble down; nibble 0 always counts as significant.
  always_comb begin
    lead_seen = 1'b0;
    blanked   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (bcd[4*i +: 4] != 4'd0 || i == 0) lead_seen = 1'b1;
      blanked[i] = (BLANK_LEADING && !lead_seen) ? BLANK_CODE : bcd[4*i +: 4];
    end
  end

  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    digit_code_d = digit_code_q;
    count_code_d = count_code_q;
    digit_cap_d  = accept ? res.res_digit : digit_cap_q;
    if (clear) begin
      state_d      = IDLE;
      digit_code_d = BLANK_CODE;
      count_code_d = {NUM_DIGITS{BLANK_CODE}};
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = CONVERT;
        CONVERT: if (bcd_done) state_d = UPDATE;
        UPDATE: begin
          digit_code_d = digit_cap_q;
          count_code_d = blanked;
          done_d       = 1'b1;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      digit_cap_q  <= '0;
      digit_code_q <= BLANK_CODE;
      count_code_q <= {NUM_DIGITS{BLANK_CODE}};
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      digit_cap_q  <= digit_cap_d;
      digit_code_q <= digit_code_d;
      count_code_q <= count_code_d;
    end
  end

  segment7 u_seg_digit (.code(digit_code_q), .seg(hex_digit));

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
    segment7 u_seg (.code(count_code_q[g]), .seg(hex_count[g]));
  end

  assign busy        = busy_q;
  assign update_done = done_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_result_display_ctrl.sv
// Directed bench for result_display_ctrl: handshake, latency, BCD/blanking,
// back-to-back acceptance, clear abort, async reset and the unblanked variant.
module tb_result_display_ctrl;
  import result_disp_pkg::*;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SB = 7'b1111111;
  localparam logic [34:0] ALL_BLANK = {35{1'b1}};

  logic clk = 1'b0;
  logic reset, clear;
  always #5 clk = ~clk;

  result_display_ctrl_if #(.COUNT_W(16)) res_if ();
  result_display_ctrl_if #(.COUNT_W(16)) res_if2 ();

  logic             busy, update_done, busy2, update_done2;
  logic [6:0]       hex_digit, hex_digit2;
  logic [4:0][6:0]  hex_count, hex_count2;
  state_e           state_dbg, state_dbg2;

  result_display_ctrl #(.COUNT_W(16), .NUM_DIGITS(5), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .reset(reset), .res(res_if.slave), .clear(clear), .busy(busy),
    .update_done(update_done), .hex_digit(hex_digit), .hex_count(hex_count),
    .state_dbg(state_dbg)
  );

  result_display_ctrl #(.COUNT_W(16), .NUM_DIGITS(5), .BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .res(res_if2.slave), .clear(clear), .busy(busy2),
    .update_done(update_done2), .hex_digit(hex_digit2), .hex_count(hex_count2),
    .state_dbg(state_dbg2)
  );

  int n_vec = 0;
  int n_err = 0;

  // Present a result, wait for acceptance, drop valid; returns at the negedge after the handshake edge.
  task automatic start_xfer(input logic [3:0] d, input logic [15:0] c);
    bit ok;
    @(negedge clk);
    res_if.res_valid = 1'b1;
    res_if.res_digit = d;
    res_if.res_count = c;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (res_if.res_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL handshake_timeout got ready=0 exp ready=1"); end
    @(posedge clk);
    @(negedge clk);
    res_if.res_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (update_done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0;
    res_if.res_valid = 1'b0;  res_if.res_digit = '0;  res_if.res_count = '0;
    res_if2.res_valid = 1'b0; res_if2.res_digit = '0; res_if2.res_count = '0;
    repeat (2) @(negedge clk);
    n_vec++; if (hex_digit !== SB) begin n_err++; $display("FAIL reset_hex_digit got %b exp %b", hex_digit, SB); end
    n_vec++; if (hex_count !== ALL_BLANK) begin n_err++; $display("FAIL reset_hex_count got %h exp %h", hex_count, ALL_BLANK); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++; if (update_done !== 1'b0) begin n_err++; $display("FAIL reset_update_done got %b exp 0", update_done); end
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (res_if.res_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", res_if.res_ready); end
    n_vec++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL reset_state got %0d exp %0d", state_dbg, IDLE); end
  endtask

  task automatic test_basic();
    int lat;
    start_xfer(4'd7, 16'd1234);
    n_vec++; if (res_if.res_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_drop got %b exp 0", res_if.res_ready); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b exp 1", busy); end
    wait_done(lat);
    n_vec++; if (lat != 17) begin n_err++; $display("FAIL basic_latency got %0d exp 17", lat); end
    n_vec++; if (hex_digit !== S7) begin n_err++; $display("FAIL basic_hex_digit got %b exp %b", hex_digit, S7); end
    n_vec++; if (hex_count !== {SB, S1, S2, S3, S4}) begin n_err++; $display("FAIL basic_hex_count got %h exp %h", hex_count, {SB, S1, S2, S3, S4}); end
    @(negedge clk);
    n_vec++; if (update_done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got %b exp 0", update_done); end
    n_vec++; if (res_if.res_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_back got %b exp 1", res_if.res_ready); end
    repeat (10) @(negedge clk);
    n_vec++; if (hex_count !== {SB, S1, S2, S3, S4}) begin n_err++; $display("FAIL basic_hold got %h exp %h", hex_count, {SB, S1, S2, S3, S4}); end
  endtask

  task automatic test_zero();
    int lat;
    start_xfer(4'd0, 16'd0);
    wait_done(lat);
    n_vec++; if (lat != 17) begin n_err++; $display("FAIL zero_latency got %0d exp 17", lat); end
    n_vec++; if (hex_digit !== S0) begin n_err++; $display("FAIL zero_hex_digit got %b exp %b", hex_digit, S0); end
    n_vec++; if (hex_count !== {SB, SB, SB, SB, S0}) begin n_err++; $display("FAIL zero_hex_count got %h exp %h", hex_count, {SB, SB, SB, SB, S0}); end
  endtask

  task automatic test_max();
    int lat;
    start_xfer(4'd12, 16'd65535);
    wait_done(lat);
    n_vec++; if (lat != 17) begin n_err++; $display("FAIL max_latency got %0d exp 17", lat); end
    n_vec++; if (hex_digit !== SB) begin n_err++; $display("FAIL max_hex_digit got %b exp %b", hex_digit, SB); end
    n_vec++; if (hex_count !== {S6, S5, S5, S3, S5}) begin n_err++; $display("FAIL max_hex_count got %h exp %h", hex_count, {S6, S5, S5, S3, S5}); end
  endtask

  task automatic test_back_to_back();
    int acc, dones, first_lat, second_lat;
    acc = 0; dones = 0; first_lat = 0; second_lat = 0;
    start_xfer(4'd3, 16'd100);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (acc != 0 && k == acc) res_if.res_valid = 1'b0;
      if (k == 1) begin
        res_if.res_valid = 1'b1; res_if.res_digit = 4'd9; res_if.res_count = 16'd9876;
      end
      if (update_done) begin
        dones++;
        if (dones == 1) begin
          first_lat = k;
          n_vec++; if (hex_count !== {SB, SB, S1, S0, S0}) begin n_err++; $display("FAIL b2b_first_count got %h exp %h", hex_count, {SB, SB, S1, S0, S0}); end
          n_vec++; if (hex_digit !== S3) begin n_err++; $display("FAIL b2b_first_digit got %b exp %b", hex_digit, S3); end
        end else begin
          second_lat = k;
        end
      end
      if (acc == 0 && res_if.res_valid && res_if.res_ready) acc = k + 1;
    end
    n_vec++; if (first_lat != 17) begin n_err++; $display("FAIL b2b_first_latency got %0d exp 17", first_lat); end
    n_vec++; if (acc != 18) begin n_err++; $display("FAIL b2b_accept_edge got %0d exp 18", acc); end
    n_vec++; if (second_lat != 35) begin n_err++; $display("FAIL b2b_second_latency got %0d exp 35", second_lat); end
    n_vec++; if (dones != 2) begin n_err++; $display("FAIL b2b_update_count got %0d exp 2", dones); end
    n_vec++; if (hex_count !== {SB, S9, S8, S7, S6}) begin n_err++; $display("FAIL b2b_second_count got %h exp %h", hex_count, {SB, S9, S8, S7, S6}); end
    n_vec++; if (hex_digit !== S9) begin n_err++; $display("FAIL b2b_second_digit got %b exp %b", hex_digit, S9); end
  endtask

  task automatic test_clear_abort();
    int dones;
    start_xfer(4'd5, 16'd321);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    clear = 1'b1;
    #1;
    n_vec++; if (res_if.res_ready !== 1'b0) begin n_err++; $display("FAIL clear_ready_low got %b exp 0", res_if.res_ready); end
    @(negedge clk);
    clear = 1'b0;
    #1;
    n_vec++; if (hex_digit !== SB) begin n_err++; $display("FAIL clear_hex_digit got %b exp %b", hex_digit, SB); end
    n_vec++; if (hex_count !== ALL_BLANK) begin n_err++; $display("FAIL clear_hex_count got %h exp %h", hex_count, ALL_BLANK); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL clear_busy got %b exp 0", busy); end
    n_vec++; if (res_if.res_ready !== 1'b1) begin n_err++; $display("FAIL clear_ready got %b exp 1", res_if.res_ready); end
    dones = 0;
    repeat (30) begin @(negedge clk); if (update_done) dones++; end
    n_vec++; if (dones != 0) begin n_err++; $display("FAIL clear_no_done got %0d exp 0", dones); end
    // clear and valid together in IDLE: nothing may be accepted
    @(negedge clk);
    clear = 1'b1;
    res_if.res_valid = 1'b1; res_if.res_digit = 4'd1; res_if.res_count = 16'd1;
    #1;
    n_vec++; if (res_if.res_ready !== 1'b0) begin n_err++; $display("FAIL clearvalid_ready got %b exp 0", res_if.res_ready); end
    @(negedge clk);
    clear = 1'b0;
    res_if.res_valid = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL clearvalid_busy got %b exp 0", busy); end
    n_vec++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL clearvalid_state got %0d exp %0d", state_dbg, IDLE); end
    dones = 0;
    repeat (20) begin @(negedge clk); if (update_done) dones++; end
    n_vec++; if (dones != 0) begin n_err++; $display("FAIL clearvalid_no_done got %0d exp 0", dones); end
    n_vec++; if (hex_count !== ALL_BLANK) begin n_err++; $display("FAIL clearvalid_count got %h exp %h", hex_count, ALL_BLANK); end
  endtask

  task automatic test_async_reset();
    int lat, dones;
    start_xfer(4'd2, 16'd55);
    wait_done(lat);
    n_vec++; if (hex_count !== {SB, SB, SB, S5, S5}) begin n_err++; $display("FAIL areset_pre_count got %h exp %h", hex_count, {SB, SB, SB, S5, S5}); end
    start_xfer(4'd4, 16'd999);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_vec++; if (hex_digit !== SB) begin n_err++; $display("FAIL areset_hex_digit got %b exp %b", hex_digit, SB); end
    n_vec++; if (hex_count !== ALL_BLANK) begin n_err++; $display("FAIL areset_hex_count got %h exp %h", hex_count, ALL_BLANK); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_busy got %b exp 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (25) begin @(negedge clk); if (update_done) dones++; end
    n_vec++; if (dones != 0) begin n_err++; $display("FAIL areset_no_done got %0d exp 0", dones); end
    n_vec++; if (res_if.res_ready !== 1'b1) begin n_err++; $display("FAIL areset_ready got %b exp 1", res_if.res_ready); end
  endtask

  task automatic test_no_blank();
    int lat;
    @(negedge clk);
    n_vec++; if (res_if2.res_ready !== 1'b1) begin n_err++; $display("FAIL noblank_ready got %b exp 1", res_if2.res_ready); end
    res_if2.res_valid = 1'b1; res_if2.res_digit = 4'd1; res_if2.res_count = 16'd42;
    @(posedge clk);
    @(negedge clk);
    res_if2.res_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (update_done2) begin lat = k; break; end
    end
    n_vec++; if (lat != 17) begin n_err++; $display("FAIL noblank_latency got %0d exp 17", lat); end
    n_vec++; if (hex_count2 !== {S0, S0, S0, S4, S2}) begin n_err++; $display("FAIL noblank_count got %h exp %h", hex_count2, {S0, S0, S0, S4, S2}); end
    n_vec++; if (hex_digit2 !== S1) begin n_err++; $display("FAIL noblank_digit got %b exp %b", hex_digit2, S1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_max();
    test_back_to_back();
    test_clear_abort();
    test_async_reset();
    test_no_blank();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got no finish exp finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/result_display_ctrl.md
Name: result_display_ctrl

Overview:
- Display sequencer between the classifier result path and the board's seven-segment displays.
- Accepts a classification result (predicted digit plus a running binary count, e.g. images classified) over a valid/ready handshake.
- Converts the count to BCD with a sequential shift-add-3 engine and blanks leading zeros.
- Holds the six HEX outputs stable in registers, feeding per-digit segment7 decoders that are active-low, 7'b1111111 = blank.

Parameters:
- COUNT_W, 16, width of the binary count input.
- NUM_DIGITS, 5, decimal digits shown for the count. Must satisfy 10^NUM_DIGITS > 2^COUNT_W - 1; elaboration-time assertion.
- BLANK_LEADING, 1, 1 = blank leading zeros of the count; 0 = show all digits.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- res_valid  in  1  result present.
- res_ready  out  1  block can accept a result.
- res_digit  in  4  predicted class 0-9; 10-15 displays blank.
- res_count  in  COUNT_W  binary count to display.
- clear  in  1  synchronous blank-all/abort request.
- busy  out  1  conversion in progress.
- update_done  out  1  one-cycle pulse when displays are refreshed.
- hex_digit  out  7  segment pattern for predicted class (HEX5).
- hex_count  out  NUM_DIGITS x 7  count segments; index 0 = least significant (HEX0).

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE; shift/BCD registers go to 0.
  - All displayed BCD codes go to 4'hF, so all hex outputs read 7'b1111111.
  - busy = 0, update_done = 0, res_ready = 1 once reset deasserts.
- FSM states are IDLE, CONVERT, UPDATE.
- IDLE:
  - res_ready = !clear.
  - On res_valid && res_ready: capture res_digit and res_count, clear the BCD accumulator, load bit counter = COUNT_W, go to CONVERT.
- CONVERT, one step per cycle for COUNT_W cycles:
  - Each BCD nibble >= 5 gets +3.
  - Then {bcd, shift} shifts left 1 and the bit counter decrements.
  - After the COUNT_W-th shift, go to UPDATE.
  - busy = 1 and res_ready = 0.
- UPDATE, one cycle:
  - Write the display registers: digit code = captured res_digit; count codes = BCD nibbles.
  - If BLANK_LEADING, every nibble above the most significant nonzero nibble is replaced by 4'hF.
  - Nibble 0 is never blanked, so a count of 0 shows "0".
  - busy = 1; next state IDLE.
- update_done is registered; it pulses high for the cycle after the UPDATE edge.
- Latency:
  - Handshake edge T; display registers change at edge T+COUNT_W+1.
  - update_done is high during cycle T+COUNT_W+1.
  - A new result can be accepted at edge T+COUNT_W+2 at the earliest.
- res_valid while busy: ignored (ready low). The source must hold it; no buffering.
- clear (any state):
  - Abort any conversion and return to IDLE.
  - Set all display codes to 4'hF; no update_done pulse.
  - clear together with res_valid in IDLE: clear wins and nothing is accepted.
- Display registers hold their value indefinitely between updates.
- res_digit 10-15 and code 4'hF decode to blank through the segment7 default branch.
- Segment decoding is combinational from the display registers, so hex outputs carry no extra cycle.

Decomposition:
- Shared package result_disp_pkg:
  - state enum (IDLE, CONVERT, UPDATE);
  - BLANK_CODE = 4'hF;
  - SEG_BLANK = 7'b1111111.
- Sub-module bin_to_bcd_seq (parameters COUNT_W, NUM_DIGITS):
  - start/done handshake and the shift-add-3 datapath.
  - The top keeps the FSM, capture, blanking and display registers.
- Instantiate NUM_DIGITS+1 existing segment7 decoders.

Test Plan:
- Reset, then res_digit=7, res_count=1234 for one cycle:
  - res_ready drops next cycle.
  - update_done at cycle 17 after the handshake edge.
  - hex_digit=7'b1111000.
  - hex_count[3:0]=1111001,0100100,0110000,0011001 (1,2,3,4).
  - hex_count[4]=7'b1111111.
- res_count=0, res_digit=0:
  - hex_count[0]=7'b1000000; all other count digits blank.
  - hex_digit=7'b1000000.
- res_count=65535: all five count digits show 6,5,5,3,5. res_digit=12: hex_digit blank.
- Second res_valid held from cycle 2 of a conversion:
  - Not accepted until res_ready rises.
  - Accepted exactly once; display shows the second value after its own 17-cycle latency.
- Mid-conversion stimulus:
  - clear at cycle 5 of CONVERT: all outputs blank next cycle, no update_done, res_ready = 1.
  - Async reset asserted mid-conversion: all outputs blank immediately.
- BLANK_LEADING=0 with res_count=42: hex_count shows 0,0,0,4,2.
